mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_pkg.sv | 28 ++
 rtl/mult_cmd_decode.sv | 73 +++++++
 rtl/mult_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_mult_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiplier command sequencer: command word width,
// opcode constants and class prefixes, and the sequencer state encoding.
// -----------------------------------------------------------------------------
package mult_pkg;

    // Command word width
    localparam int CMD_W = 5;

    // Full-word opcodes
    localparam logic [4:0] CMD_NOP      = 5'b00000;
    localparam logic [4:0] CMD_HALT     = 5'b11111;
    localparam logic [4:0] CMD_NEXT_ROW = 5'b10110;

    // Class prefixes (upper bits of the command word)
    localparam logic [1:0] CMD_REG_PFX  = 2'b01;   // 01rrr : operand-register write
    localparam logic [2:0] CMD_DATA_PFX = 3'b100;  // 100ss : data write + result select
    localparam logic [3:0] CMD_COL_PFX  = 4'b1010; // 1010c : column level

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult_cmd_decode.sv
// -----------------------------------------------------------------------------
// mult_cmd_decode
// Purely combinational decoder from a 5-bit command word to the sequencer's
// enable set. Register-write commands addressing a register at or above
// NUM_REGS, and every unassigned encoding, act as NOP and raise illegal.
//
// Ports:
//   cmd       in   CMD_W     command word
//   reg_we    out  NUM_REGS  one-hot operand-register write enable
//   data_we   out  1         data memory write enable
//   jklm_load out  1         load jklm_sel into the result select register
//   jklm_sel  out  2         result select value
//   col_load  out  1         load col_val into the column register
//   col_val   out  1         column level
//   next_row  out  1         advance-row request
//   halt      out  1         HALT command
//   illegal   out  1         unrecognised / out-of-range command
// -----------------------------------------------------------------------------
module mult_cmd_decode
    import mult_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic [CMD_W-1:0]    cmd,
    output logic [NUM_REGS-1:0] reg_we,
    output logic                data_we,
    output logic                jklm_load,
    output logic [1:0]          jklm_sel,
    output logic                col_load,
    output logic                col_val,
    output logic                next_row,
    output logic                halt,
    output logic                illegal
);

    // Classify the command word and raise the matching enable
    always_comb begin
        reg_we    = {NUM_REGS{1'b0}};
        data_we   = 1'b0;
        jklm_load = 1'b0;
        jklm_sel  = 2'b00;
        col_load  = 1'b0;
        col_val   = 1'b0;
        next_row  = 1'b0;
        halt      = 1'b0;
        illegal   = 1'b0;
        if (cmd == CMD_NOP) begin
            illegal = 1'b0;
        end else if (cmd == CMD_HALT) begin
            halt = 1'b1;
        end else if (cmd[4:3] == CMD_REG_PFX) begin
            if (int'(cmd[2:0]) < NUM_REGS) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    reg_we[i] = (cmd[2:0] == 3'(i));
                end
            end else begin
                illegal = 1'b1;
            end
        end else if (cmd[4:2] == CMD_DATA_PFX) begin
            data_we   = 1'b1;
            jklm_load = 1'b1;
            jklm_sel  = cmd[1:0];
        end else if (cmd[4:1] == CMD_COL_PFX) begin
            col_load = 1'b1;
            col_val  = cmd[0];
        end else if (cmd == CMD_NEXT_ROW) begin
            next_row = 1'b1;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// -----------------------------------------------------------------------------
// mult_sequencer
// Steps a program counter through an external asynchronous-read program memory,
// decodes each command into registered control outputs (visible the cycle after
// the command is executed) and repeats the program for a configurable number
// of passes. A pass ends on HALT or after the command at PROG_LEN-1.
//
// Ports:
//   clk          in   1           clock, rising edge
//   rst_n        in   1           asynchronous active-low reset
//   start        in   1           begin program (honoured in IDLE only)
//   passes       in   PASS_WIDTH  pass count, sampled at start; 0 means 1
//   stall        in   1           hold sequencing this cycle
//   cmd          in   5           command word at prog_addr
//   prog_addr    out  ADDR_WIDTH  program counter
//   busy         out  1           high in RUN
//   done         out  1           one-cycle completion pulse
//   err          out  1           sticky illegal-command flag
//   data_we      out  1           data memory write enable pulse
//   reg_we       out  NUM_REGS    one-hot operand-register write enable pulse
//   jklm_select  out  2           result select (holds last loaded value)
//   next_row     out  1           advance-row pulse
//   column       out  1           column select level
// -----------------------------------------------------------------------------
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int PROG_LEN   = 256,
    parameter int NUM_REGS   = 8,
    parameter int PASS_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PASS_WIDTH-1:0] passes,
    input  logic                  stall,
    input  logic [CMD_W-1:0]      cmd,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  data_we,
    output logic [NUM_REGS-1:0]   reg_we,
    output logic [1:0]            jklm_select,
    output logic                  next_row,
    output logic                  column
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_LEN - 1);

    // Decoder outputs
    logic [NUM_REGS-1:0] dec_reg_we_s;
    logic                dec_data_we_s;
    logic                dec_jklm_load_s;
    logic [1:0]          dec_jklm_sel_s;
    logic                dec_col_load_s;
    logic                dec_col_val_s;
    logic                dec_next_row_s;
    logic                dec_halt_s;
    logic                dec_illegal_s;

    // State and registered outputs
    state_t                state_r,     state_nxt_s;
    logic [ADDR_WIDTH-1:0] prog_addr_r, prog_addr_nxt_s;
    logic [PASS_WIDTH-1:0] pass_cnt_r,  pass_cnt_nxt_s;
    logic [PASS_WIDTH-1:0] passes_r,    passes_nxt_s;
    logic                  busy_r,      busy_nxt_s;
    logic                  done_r,      done_nxt_s;
    logic                  err_r,       err_nxt_s;
    logic                  data_we_r,   data_we_nxt_s;
    logic [NUM_REGS-1:0]   reg_we_r,    reg_we_nxt_s;
    logic [1:0]            jklm_r,      jklm_nxt_s;
    logic                  next_row_r,  next_row_nxt_s;
    logic                  column_r,    column_nxt_s;
    logic                  end_of_pass_s;

    mult_cmd_decode #(
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .cmd       (cmd),
        .reg_we    (dec_reg_we_s),
        .data_we   (dec_data_we_s),
        .jklm_load (dec_jklm_load_s),
        .jklm_sel  (dec_jklm_sel_s),
        .col_load  (dec_col_load_s),
        .col_val   (dec_col_val_s),
        .next_row  (dec_next_row_s),
        .halt      (dec_halt_s),
        .illegal   (dec_illegal_s)
    );

    assign end_of_pass_s = dec_halt_s | (prog_addr_r == LAST_ADDR);

    // Next-state, counter and output decode; pulse outputs default to zero
    always_comb begin
        state_nxt_s     = state_r;
        prog_addr_nxt_s = prog_addr_r;
        pass_cnt_nxt_s  = pass_cnt_r;
        passes_nxt_s    = passes_r;
        err_nxt_s       = err_r;
        jklm_nxt_s      = jklm_r;
        column_nxt_s    = column_r;
        data_we_nxt_s   = 1'b0;
        reg_we_nxt_s    = {NUM_REGS{1'b0}};
        next_row_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s     = RUN;
                    prog_addr_nxt_s = {ADDR_WIDTH{1'b0}};
                    pass_cnt_nxt_s  = {PASS_WIDTH{1'b0}};
                    passes_nxt_s    = (passes == {PASS_WIDTH{1'b0}}) ? PASS_WIDTH'(1) : passes;
                    err_nxt_s       = 1'b0;
                    column_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                // A stalled cycle issues nothing and keeps the counter, so the
                // command at prog_addr is executed once, on its first free cycle.
                if (!stall) begin
                    data_we_nxt_s  = dec_data_we_s;
                    reg_we_nxt_s   = dec_reg_we_s;
                    next_row_nxt_s = dec_next_row_s;
                    err_nxt_s      = err_r | dec_illegal_s;
                    if (dec_jklm_load_s) begin
                        jklm_nxt_s = dec_jklm_sel_s;
                    end else begin
                        jklm_nxt_s = jklm_r;
                    end
                    if (dec_col_load_s) begin
                        column_nxt_s = dec_col_val_s;
                    end else begin
                        column_nxt_s = column_r;
                    end
                    if (!end_of_pass_s) begin
                        prog_addr_nxt_s = prog_addr_r + ADDR_WIDTH'(1);
                    end else if (pass_cnt_r < (passes_r - PASS_WIDTH'(1))) begin
                        prog_addr_nxt_s = {ADDR_WIDTH{1'b0}};
                        pass_cnt_nxt_s  = pass_cnt_r + PASS_WIDTH'(1);
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == RUN);
        done_nxt_s = (state_nxt_s == DONE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            prog_addr_r <= {ADDR_WIDTH{1'b0}};
            pass_cnt_r  <= {PASS_WIDTH{1'b0}};
            passes_r    <= {PASS_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            data_we_r   <= 1'b0;
            reg_we_r    <= {NUM_REGS{1'b0}};
            jklm_r      <= 2'b00;
            next_row_r  <= 1'b0;
            column_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            prog_addr_r <= prog_addr_nxt_s;
            pass_cnt_r  <= pass_cnt_nxt_s;
            passes_r    <= passes_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            err_r       <= err_nxt_s;
            data_we_r   <= data_we_nxt_s;
            reg_we_r    <= reg_we_nxt_s;
            jklm_r      <= jklm_nxt_s;
            next_row_r  <= next_row_nxt_s;
            column_r    <= column_nxt_s;
        end
    end

    assign prog_addr   = prog_addr_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign data_we     = data_we_r;
    assign reg_we      = reg_we_r;
    assign jklm_select = jklm_r;
    assign next_row    = next_row_r;
    assign column      = column_r;

endmodule

// File: tb/tb_mult_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_sequencer
// Directed bench for mult_sequencer configured with a 4-entry program,
// four operand registers and a 3-bit address, so both end-of-pass causes
// (HALT and last address) and the out-of-range register command are reachable.
// -----------------------------------------------------------------------------
module tb_mult_sequencer;

    localparam int AW = 3;
    localparam int PL = 4;
    localparam int NR = 4;
    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [PW-1:0] passes;
    logic          stall;
    logic [4:0]    cmd;
    logic [AW-1:0] prog_addr;
    logic          busy;
    logic          done;
    logic          err;
    logic          data_we;
    logic [NR-1:0] reg_we;
    logic [1:0]    jklm_select;
    logic          next_row;
    logic          column;

    logic [4:0] prog_mem [0:7];

    int total = 0;
    int bad   = 0;

    mult_sequencer #(
        .ADDR_WIDTH (AW),
        .PROG_LEN   (PL),
        .NUM_REGS   (NR),
        .PASS_WIDTH (PW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .passes      (passes),
        .stall       (stall),
        .cmd         (cmd),
        .prog_addr   (prog_addr),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .data_we     (data_we),
        .reg_we      (reg_we),
        .jklm_select (jklm_select),
        .next_row    (next_row),
        .column      (column)
    );

    assign cmd = prog_mem[prog_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [4:0] c0, input logic [4:0] c1,
                        input logic [4:0] c2, input logic [4:0] c3);
        prog_mem[0] = c0;
        prog_mem[1] = c1;
        prog_mem[2] = c2;
        prog_mem[3] = c3;
        for (int i = 4; i < 8; i++) prog_mem[i] = 5'b00000;
    endtask

    task automatic enables_zero(input string tag);
        check({tag, "_data_we"},  32'(data_we),  32'd0);
        check({tag, "_reg_we"},   32'(reg_we),   32'd0);
        check({tag, "_next_row"}, 32'(next_row), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        passes = 4'd1;
        stall  = 1'b0;
        load(5'b00000, 5'b00000, 5'b00000, 5'b00000);

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_addr", 32'(prog_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err",  32'(err),  32'd0);
        check("rst_jklm", 32'(jklm_select), 32'd0);
        check("rst_col",  32'(column), 32'd0);
        enables_zero("rst");
        rst_n = 1'b1;
        tick();

        // ---------------- basic program with HALT ----------------
        load(5'b01000, 5'b10010, 5'b10110, 5'b11111);
        passes = 4'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("p1_busy0", 32'(busy), 32'd1);
        check("p1_addr0", 32'(prog_addr), 32'd0);
        tick();
        check("p1_regwe", 32'(reg_we), 32'h1);
        check("p1_addr1", 32'(prog_addr), 32'd1);
        tick();
        check("p1_datawe", 32'(data_we), 32'd1);
        check("p1_jklm",   32'(jklm_select), 32'd2);
        check("p1_regwe0", 32'(reg_we), 32'd0);
        tick();
        check("p1_nextrow", 32'(next_row), 32'd1);
        check("p1_dwe0",    32'(data_we), 32'd0);
        check("p1_jklm_h",  32'(jklm_select), 32'd2);
        tick();
        check("p1_done",  32'(done), 32'd1);
        check("p1_busyl", 32'(busy), 32'd0);
        check("p1_addrh", 32'(prog_addr), 32'd3);
        check("p1_err",   32'(err), 32'd0);
        enables_zero("p1_halt");
        tick();
        check("p1_done_off", 32'(done), 32'd0);
        check("p1_idle",     32'(busy), 32'd0);

        // ---------------- three passes, no HALT ----------------
        load(5'b00000, 5'b00000, 5'b00000, 5'b00000);
        passes = 4'd3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check("p3_addr", 32'(prog_addr), 32'(k % 4));
            check("p3_busy", 32'(busy), 32'd1);
            check("p3_nodone", 32'(done), 32'd0);
            tick();
        end
        check("p3_done", 32'(done), 32'd1);
        check("p3_addr_end", 32'(prog_addr), 32'd3);
        tick();
        check("p3_done_once", 32'(done), 32'd0);
        tick();
        check("p3_done_once2", 32'(done), 32'd0);

        // ---------------- stall at prog_addr=1 ----------------
        load(5'b10001, 5'b01010, 5'b10110, 5'b11111);
        passes = 4'd1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("st_dwe", 32'(data_we), 32'd1);
        check("st_addr1", 32'(prog_addr), 32'd1);
        stall = 1'b1;
        tick();
        check("st_hold1", 32'(prog_addr), 32'd1);
        enables_zero("st_c1");
        check("st_jklm_h", 32'(jklm_select), 32'd1);
        tick();
        check("st_hold2", 32'(prog_addr), 32'd1);
        enables_zero("st_c2");
        stall = 1'b0;
        tick();
        check("st_regwe", 32'(reg_we), 32'h4);
        check("st_addr2", 32'(prog_addr), 32'd2);
        tick();
        check("st_regwe_once", 32'(reg_we), 32'd0);
        check("st_nextrow", 32'(next_row), 32'd1);
        tick();
        check("st_done", 32'(done), 32'd1);

        // ---------------- illegal commands ----------------
        tick();
        load(5'b00000, 5'b01111, 5'b00000, 5'b11111);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("il_err_pre", 32'(err), 32'd0);
        tick();
        check("il_err_reg", 32'(err), 32'd1);
        enables_zero("il_reg");
        tick();
        check("il_sticky", 32'(err), 32'd1);
        tick();
        check("il_done", 32'(done), 32'd1);
        tick();
        check("il_sticky_idle", 32'(err), 32'd1);
        load(5'b11000, 5'b00000, 5'b00000, 5'b11111);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("il_cleared", 32'(err), 32'd0);
        tick();
        check("il_err_11000", 32'(err), 32'd1);
        enables_zero("il_11000");
        repeat (4) tick();

        // ---------------- reset during pass 2 ----------------
        load(5'b11000, 5'b10101, 5'b10010, 5'b00000);
        passes = 4'd2;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("rs_addr_p2", 32'(prog_addr), 32'd1);
        check("rs_col_set", 32'(column), 32'd1);
        check("rs_err_set", 32'(err), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs_addr",  32'(prog_addr), 32'd0);
        check("rs_busy",  32'(busy), 32'd0);
        check("rs_done",  32'(done), 32'd0);
        check("rs_err",   32'(err), 32'd0);
        check("rs_col",   32'(column), 32'd0);
        check("rs_jklm",  32'(jklm_select), 32'd0);
        enables_zero("rs");
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rs_no_done", 32'(done), 32'd0);
            check("rs_idle", 32'(busy), 32'd0);
        end

        // ---------------- passes=0 and start ignored while busy ----------------
        load(5'b00000, 5'b00000, 5'b00000, 5'b00000);
        passes = 4'd0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("z_addr0", 32'(prog_addr), 32'd0);
        check("z_busy",  32'(busy), 32'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("z_ign_addr", 32'(prog_addr), 32'd2);
        tick();
        check("z_addr3", 32'(prog_addr), 32'd3);
        tick();
        check("z_one_pass", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("z_done_idle", 32'(done), 32'd0);
        check("z_ign_done",  32'(busy), 32'd0);
        tick();
        check("z_still_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
